// File: rtl/sar_adc_fsm_param.sv
// Successive-approximation ADC controller: sample/fire/wait sequencing per bit,
// optional averaging of 2^OSR_LOG2 conversions and a one-point offset calibration.
module sar_adc_fsm_param #(
  parameter int WIDTH      = 10,
  parameter int OSR_LOG2   = 0,
  parameter int SAMPLE_CYC = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st_conv,
  input  logic             cal,
  input  logic             comp_done,
  input  logic             comp_result,
  output logic             sample,
  output logic             fire_comp,
  output logic [WIDTH-1:0] dac_value,
  output logic [WIDTH-1:0] result,
  output logic             adc_done,
  output logic             busy,
  output logic             cal_valid,
  output logic             timeout_err
);

  localparam int SUM_W = WIDTH + OSR_LOG2;
  localparam int K_W   = $clog2(WIDTH);
  localparam int REP_W = (OSR_LOG2 > 0) ? OSR_LOG2 : 1;
  localparam int MID   = 1 << (WIDTH - 1);

  localparam logic [REP_W-1:0] REP_LAST    = REP_W'((1 << OSR_LOG2) - 1);
  localparam logic [7:0]       SAMPLE_LAST = 8'(SAMPLE_CYC - 1);
  localparam logic [7:0]       WAIT_LAST   = 8'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
  localparam logic [K_W-1:0]   K_TOP       = K_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    FIRE,
    WAIT,
    DONE
  } state_t;

  state_t                  state_reg, state_next;
  logic                    cal_mode_reg, cal_mode_next;
  logic [SUM_W-1:0]        sum_reg, sum_next;
  logic [WIDTH-1:0]        acc_reg, acc_next;
  logic [K_W-1:0]          k_reg, k_next;
  logic [REP_W-1:0]        rep_reg, rep_next;
  logic [7:0]              cnt_reg, cnt_next;
  logic signed [WIDTH:0]   offset_reg, offset_next;

  logic                    sample_reg, sample_next;
  logic                    fire_reg, fire_next;
  logic [WIDTH-1:0]        dac_reg, dac_next;
  logic [WIDTH-1:0]        result_reg, result_next;
  logic                    adc_done_reg, adc_done_next;
  logic                    busy_reg, busy_next;
  logic                    cal_valid_reg, cal_valid_next;
  logic                    timeout_reg, timeout_next;

  // Datapath for the decision cycle: the trial code is kept only on a real "keep" answer.
  logic [WIDTH-1:0]        acc_dec;
  logic [SUM_W-1:0]        sum_new;
  logic [WIDTH-1:0]        raw;
  logic signed [WIDTH:0]   cal_offset;
  logic [WIDTH+1:0]        diff;
  logic [WIDTH-1:0]        corrected;
  logic                    wait_expired;

  assign acc_dec      = (comp_done && comp_result) ? dac_reg : acc_reg;
  assign sum_new      = sum_reg + SUM_W'(acc_dec);
  assign raw          = sum_new[SUM_W-1:OSR_LOG2];
  assign cal_offset   = $signed({1'b0, raw}) - $signed((WIDTH+1)'(MID));
  assign diff         = {2'b00, raw} - {offset_reg[WIDTH], offset_reg};
  // diff spans -(2^(WIDTH-1)-1) .. 3*2^(WIDTH-1)-1, so the top bit is the sign and the next the overflow.
  assign corrected    = diff[WIDTH+1] ? '0 : (diff[WIDTH] ? '1 : diff[WIDTH-1:0]);
  assign wait_expired = (cnt_reg == WAIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cal_mode_reg  <= 1'b0;
      sum_reg       <= '0;
      acc_reg       <= '0;
      k_reg         <= '0;
      rep_reg       <= '0;
      cnt_reg       <= '0;
      offset_reg    <= '0;
      sample_reg    <= 1'b0;
      fire_reg      <= 1'b0;
      dac_reg       <= '0;
      result_reg    <= '0;
      adc_done_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      cal_valid_reg <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cal_mode_reg  <= cal_mode_next;
      sum_reg       <= sum_next;
      acc_reg       <= acc_next;
      k_reg         <= k_next;
      rep_reg       <= rep_next;
      cnt_reg       <= cnt_next;
      offset_reg    <= offset_next;
      sample_reg    <= sample_next;
      fire_reg      <= fire_next;
      dac_reg       <= dac_next;
      result_reg    <= result_next;
      adc_done_reg  <= adc_done_next;
      busy_reg      <= busy_next;
      cal_valid_reg <= cal_valid_next;
      timeout_reg   <= timeout_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cal_mode_next  = cal_mode_reg;
    sum_next       = sum_reg;
    acc_next       = acc_reg;
    k_next         = k_reg;
    rep_next       = rep_reg;
    cnt_next       = cnt_reg;
    offset_next    = offset_reg;
    fire_next      = 1'b0;
    dac_next       = dac_reg;
    result_next    = result_reg;
    adc_done_next  = 1'b0;
    cal_valid_next = cal_valid_reg;
    timeout_next   = timeout_reg;

    case (state_reg)
      IDLE: begin
        if (st_conv) begin
          cal_mode_next = cal;
          sum_next      = '0;
          rep_next      = '0;
          cnt_next      = '0;
          dac_next      = '0;
          state_next    = SAMPLE;
        end
      end

      SAMPLE: begin
        if (cnt_reg == SAMPLE_LAST) begin
          acc_next   = '0;
          k_next     = K_TOP;
          dac_next   = ONE << K_TOP;
          fire_next  = 1'b1;
          state_next = FIRE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      FIRE: begin
        cnt_next   = '0;
        state_next = WAIT;
      end

      WAIT: begin
        if (comp_done || wait_expired) begin
          acc_next = acc_dec;
          if (!comp_done) begin
            timeout_next = 1'b1;
          end
          if (k_reg == '0) begin
            sum_next = sum_new;
            if (rep_reg != REP_LAST) begin
              rep_next   = rep_reg + REP_W'(1);
              cnt_next   = '0;
              dac_next   = '0;
              state_next = SAMPLE;
            end else begin
              adc_done_next = 1'b1;
              state_next    = DONE;
              if (cal_mode_reg) begin
                offset_next    = cal_offset;
                cal_valid_next = 1'b1;
                result_next    = raw;
              end else begin
                result_next = corrected;
              end
            end
          end else begin
            k_next     = k_reg - K_W'(1);
            dac_next   = acc_dec | (ONE << (k_reg - K_W'(1)));
            fire_next  = 1'b1;
            state_next = FIRE;
          end
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    sample_next = (state_next == SAMPLE);
    busy_next   = (state_next != IDLE);
  end

  assign sample      = sample_reg;
  assign fire_comp   = fire_reg;
  assign dac_value   = dac_reg;
  assign result      = result_reg;
  assign adc_done    = adc_done_reg;
  assign busy        = busy_reg;
  assign cal_valid   = cal_valid_reg;
  assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_sar_adc_fsm_param.sv
// Directed bench for sar_adc_fsm_param: a behavioural comparator with a programmable
// offset answers each trial; one instance without averaging, one with OSR_LOG2=2.
module tb_sar_adc_fsm_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic       st_conv_a, cal_a, comp_done_a, comp_result_a;
  logic       sample_a, fire_comp_a, adc_done_a, busy_a, cal_valid_a, timeout_err_a;
  logic [9:0] dac_a, result_a;

  // Instance B: four conversions averaged per result
  logic       st_conv_b, cal_b, comp_done_b, comp_result_b;
  logic       sample_b, fire_comp_b, adc_done_b, busy_b, cal_valid_b, timeout_err_b;
  logic [9:0] dac_b, result_b;

  sar_adc_fsm_param u_dut_a (
    .clk(clk), .rst(rst), .st_conv(st_conv_a), .cal(cal_a),
    .comp_done(comp_done_a), .comp_result(comp_result_a),
    .sample(sample_a), .fire_comp(fire_comp_a), .dac_value(dac_a), .result(result_a),
    .adc_done(adc_done_a), .busy(busy_a), .cal_valid(cal_valid_a), .timeout_err(timeout_err_a)
  );

  sar_adc_fsm_param #(.WIDTH(10), .OSR_LOG2(2), .SAMPLE_CYC(2), .TIMEOUT(15)) u_dut_b (
    .clk(clk), .rst(rst), .st_conv(st_conv_b), .cal(cal_b),
    .comp_done(comp_done_b), .comp_result(comp_result_b),
    .sample(sample_b), .fire_comp(fire_comp_b), .dac_value(dac_b), .result(result_b),
    .adc_done(adc_done_b), .busy(busy_b), .cal_valid(cal_valid_b), .timeout_err(timeout_err_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Comparator A: mode 0 = answers one cycle after fire_comp, 1 = never answers, 2 = comp_done stuck high
  int ref_a = 0, off_a = 0, mode_a = 0;
  bit fire_seen_a = 1'b0;
  always @(negedge clk) begin
    case (mode_a)
      1:       comp_done_a = 1'b0;
      2:       comp_done_a = 1'b1;
      default: comp_done_a = fire_seen_a;
    endcase
    comp_result_a = (ref_a >= int'(dac_a) + off_a);
    fire_seen_a   = fire_comp_a;
  end

  // Comparator B: input alternates 600/601 on every new sample phase
  int ref_b = 600;
  bit alt_b = 1'b0, samp_prev_b = 1'b0, fire_seen_b = 1'b0;
  always @(negedge clk) begin
    if (sample_b && !samp_prev_b) begin
      ref_b = alt_b ? 601 : 600;
      alt_b = !alt_b;
    end
    samp_prev_b   = sample_b;
    comp_done_b   = fire_seen_b;
    comp_result_b = (ref_b >= int'(dac_b));
    fire_seen_b   = fire_comp_b;
  end

  task automatic run_a(input bit c, output int lat, output logic [9:0] res, output logic cv,
                       output logic done_after, output logic busy_after);
    @(negedge clk);
    st_conv_a = 1'b1;
    cal_a     = c;
    @(posedge clk);
    #1;
    st_conv_a = 1'b0;
    cal_a     = 1'b0;
    lat = 0;
    while (!adc_done_a && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result_a;
    cv  = cal_valid_a;
    @(posedge clk);
    #1;
    done_after = adc_done_a;
    busy_after = busy_a;
  endtask

  int         lat, fires, guard, cnt;
  logic [9:0] res;
  logic       cv, da, ba;

  initial begin
    rst = 1'b1;
    st_conv_a = 1'b0; cal_a = 1'b0; st_conv_b = 1'b0; cal_b = 1'b0;
    comp_done_a = 1'b0; comp_result_a = 1'b0; comp_done_b = 1'b0; comp_result_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sample", sample_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_result", result_a, 0);
    check("rst_cal_valid", cal_valid_a, 0);
    check("rst_timeout", timeout_err_a, 0);
    rst = 1'b0;

    // Calibration with comparator offset 100, then corrected conversions
    off_a = 100; ref_a = 512;
    run_a(1'b1, lat, res, cv, da, ba);
    check("cal512_lat", lat, 22);
    check("cal512_result", res, 412);
    check("cal512_valid", cv, 1);
    check("cal512_done_pulse", da, 0);
    check("cal512_idle", ba, 0);
    ref_a = 300;
    run_a(1'b0, lat, res, cv, da, ba);
    check("conv300_result", res, 300);
    check("conv300_lat", lat, 22);
    ref_a = 1000;
    run_a(1'b0, lat, res, cv, da, ba);
    check("conv1000_result", res, 1000);

    // Recalibration with zero comparator offset overwrites the stored offset (-112)
    off_a = 0; ref_a = 400;
    run_a(1'b1, lat, res, cv, da, ba);
    check("cal400_result", res, 400);
    ref_a = 200;
    run_a(1'b0, lat, res, cv, da, ba);
    check("conv200_result", res, 312);
    ref_a = 1023;
    run_a(1'b0, lat, res, cv, da, ba);
    check("conv1023_sat", res, 1023);

    // comp_done stuck high must give the same code and timing as the clean handshake
    ref_a = 555;
    run_a(1'b0, lat, res, cv, da, ba);
    check("clean555_result", res, 667);
    mode_a = 2;
    run_a(1'b0, lat, res, cv, da, ba);
    check("held555_result", res, 667);
    check("held555_lat", lat, 22);
    mode_a = 0;

    // Reset in the middle of bit 5
    ref_a = 700;
    @(negedge clk);
    st_conv_a = 1'b1;
    @(posedge clk);
    #1;
    st_conv_a = 1'b0;
    fires = 0; guard = 0;
    while (fires < 5 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
      if (fire_comp_a) fires++;
    end
    check("midrst_bit5_reached", fires, 5);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy_a, 0);
    check("midrst_dac", dac_a, 0);
    check("midrst_result", result_a, 0);
    check("midrst_cal_valid", cal_valid_a, 0);
    check("midrst_sample", sample_a, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (adc_done_a || busy_a) cnt++;
    end
    check("midrst_no_done", cnt, 0);
    run_a(1'b0, lat, res, cv, da, ba);
    check("after_rst700_result", res, 700);

    // Offset is zero after reset: ref 0 converts to 0
    ref_a = 0;
    run_a(1'b0, lat, res, cv, da, ba);
    check("conv0_result", res, 0);

    // Silent comparator: every bit times out
    mode_a = 1; ref_a = 900;
    run_a(1'b0, lat, res, cv, da, ba);
    check("tmo_lat", lat, 162);
    check("tmo_result", res, 0);
    check("tmo_flag", timeout_err_a, 1);
    mode_a = 0; ref_a = 300;
    run_a(1'b0, lat, res, cv, da, ba);
    check("tmo_then300_result", res, 300);
    check("tmo_sticky", timeout_err_a, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("tmo_cleared", timeout_err_a, 0);

    // Averaged conversion with st_conv pulses while busy
    @(negedge clk);
    st_conv_b = 1'b1;
    @(posedge clk);
    #1;
    st_conv_b = 1'b0;
    lat = 0;
    while (!adc_done_b && lat < 3000) begin
      @(posedge clk);
      #1;
      lat++;
      st_conv_b = (lat == 30 || lat == 60);
    end
    st_conv_b = 1'b0;
    check("osr_lat", lat, 88);
    check("osr_result", result_b, 600);
    check("osr_cal_valid", cal_valid_b, 0);
    @(posedge clk);
    #1;
    check("osr_done_pulse", adc_done_b, 0);
    cnt = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (busy_b || adc_done_b) cnt++;
    end
    check("osr_no_restart", cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
